// File: rtl/arb4_rr.sv
// ============================================================================
// Module   : arb4_rr
// Purpose  : Four-requester arbiter with round-robin or fixed priority
//            selection and a hold timer that forces hand-off under contention.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module arb4_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       req2,
    input  logic       req3,
    input  logic       prio_mode,
    output logic       gnt0,
    output logic       gnt1,
    output logic       gnt2,
    output logic       gnt3,
    output logic [1:0] gnt_id,
    output logic       busy
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_GRANT  = 1'b1;
    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_id;
    logic [7:0] r_cnt;
    logic [1:0] r_last;

    logic [0:0] w_state_nx;
    logic [3:0] w_gnt_nx;
    logic [1:0] w_id_nx;
    logic [7:0] w_cnt_nx;
    logic [1:0] w_last_nx;

    logic [3:0] w_req;
    logic [3:0] w_others;
    logic [2:0] w_pick_all;
    logic [2:0] w_pick_oth;
    logic       w_do_grant;
    logic [1:0] w_win;

    // Returns {found, index}; round-robin starts just after the last winner,
    // fixed priority scans 3 down to 0.
    function automatic logic [2:0] f_pick(input logic [3:0] cand,
                                          input logic       fixed,
                                          input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (fixed) idx = 2'(3 - i);
            else       idx = last + 2'(i + 1);
            if (!res[2] && cand[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_req      = {req3, req2, req1, req0};
    assign w_others   = w_req & ~r_gnt;
    assign w_pick_all = f_pick(w_req, prio_mode, r_last);
    assign w_pick_oth = f_pick(w_others, prio_mode, r_last);

    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_id_nx    = r_id;
        w_cnt_nx   = r_cnt;
        w_last_nx  = r_last;
        w_do_grant = 1'b0;
        w_win      = 2'b00;

        case (r_state)
            c_ST_IDLE: begin
                if (w_pick_all[2]) begin
                    w_do_grant = 1'b1;
                    w_win      = w_pick_all[1:0];
                end
            end
            c_ST_GRANT: begin
                if (!w_req[r_id]) begin
                    if (w_pick_oth[2]) begin
                        w_do_grant = 1'b1;
                        w_win      = w_pick_oth[1:0];
                    end else begin
                        w_state_nx = c_ST_IDLE;
                        w_gnt_nx   = 4'b0000;
                        w_id_nx    = 2'b00;
                        w_cnt_nx   = 8'd0;
                    end
                end else if (r_cnt == c_HOLD_LAST) begin
                    // Timeout: hand off if anyone else waits, else restart window.
                    if (w_pick_oth[2]) begin
                        w_do_grant = 1'b1;
                        w_win      = w_pick_oth[1:0];
                    end else begin
                        w_cnt_nx = 8'd0;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
                w_gnt_nx   = 4'b0000;
                w_id_nx    = 2'b00;
                w_cnt_nx   = 8'd0;
            end
        endcase

        if (w_do_grant) begin
            w_state_nx = c_ST_GRANT;
            w_gnt_nx   = 4'b0001 << w_win;
            w_id_nx    = w_win;
            w_cnt_nx   = 8'd0;
            w_last_nx  = w_win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_gnt   <= 4'b0000;
            r_id    <= 2'b00;
            r_cnt   <= 8'd0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_id    <= w_id_nx;
            r_cnt   <= w_cnt_nx;
            r_last  <= w_last_nx;
        end
    end

    assign gnt0   = r_gnt[0];
    assign gnt1   = r_gnt[1];
    assign gnt2   = r_gnt[2];
    assign gnt3   = r_gnt[3];
    assign gnt_id = r_id;
    assign busy   = (r_state == c_ST_GRANT);

endmodule

`default_nettype wire
